// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one RAM port between CPU (C) and DMA (D).
// Ports: c_*/d_* request/grant/done, mem_* RAM side, rdata, owner, busy.
module dmem_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_op,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_q;
  logic        wr_q;
  logic        owner_q;
  logic        c_gnt_q;
  logic        d_gnt_q;
  logic        c_done_q;
  logic        d_done_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [2:0]  mem_op_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;

  // Winner of the current IDLE cycle: 1 = DMA.
  // On a tie, round-robin picks whoever did not win last.
  logic win_d;
  logic sel_we_d;

  always_comb begin
    win_d = 1'b0;
    unique case (1'b1)
      (c_req && d_req):  win_d = (CPU_PRIO != 0) ? 1'b0 : ~last_q;
      (d_req && !c_req): win_d = 1'b1;
      default:           win_d = 1'b0;
    endcase
    sel_we_d = win_d ? d_we : c_we;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      wr_q        <= 1'b0;
      owner_q     <= 1'b0;
      c_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      c_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_op_q    <= 3'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      c_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      c_done_q <= 1'b0;
      d_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (c_req || d_req) begin
            wr_q        <= sel_we_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we_d;
            mem_op_q    <= win_d ? d_op : c_op;
            mem_addr_q  <= win_d ? d_addr : c_addr;
            mem_wdata_q <= win_d ? d_wdata : c_wdata;
            owner_q     <= win_d;
            last_q      <= win_d;
            c_gnt_q     <= ~win_d;
            d_gnt_q     <= win_d;
            cnt_q       <= sel_we_d ? 4'd0 : RD_CNT;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          // Write strobe lasts only the first ACCESS cycle.
          mem_we_q <= 1'b0;
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_q) rdata_q <= mem_rdata;
            mem_en_q <= 1'b0;
            c_done_q <= ~owner_q;
            d_done_q <= owner_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign c_gnt     = c_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign c_done    = c_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

endmodule
